// File: rtl/csr_req_tracker.sv
// CSR request tracker: captures one WB-stage CSR access, runs the valid/ready
// handshake to the CSR unit, stalls the pipeline until the response returns and
// hands the result back to WB as a one-cycle done pulse. A watchdog turns a lost
// response into an exception, and a drain flag swallows responses that belong to
// an access that was flushed after the CSR unit had already accepted it.
module csr_req_tracker #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        csr_ena_i,
  input  logic [11:0] csr_addr_i,
  input  logic [2:0]  csr_cmd_i,
  input  logic [63:0] csr_wdata_i,
  input  logic        flush_i,
  output logic        req_valid_o,
  input  logic        req_ready_i,
  output logic [11:0] req_addr_o,
  output logic [2:0]  req_cmd_o,
  output logic [63:0] req_wdata_o,
  input  logic        resp_valid_i,
  input  logic [63:0] resp_rdata_i,
  input  logic        resp_xcpt_i,
  input  logic        resp_replay_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [63:0] rdata_o,
  output logic        xcpt_o,
  output logic        replay_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Last counter value before the watchdog fires; unused when TIMEOUT_CYCLES is 0.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit               WD_ON    = (TIMEOUT_CYCLES != 0);

  state_t           state_q, state_d;
  logic             drain_q, drain_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             capture;
  logic             take_resp;
  logic             take_timeout;
  logic             expire;

  logic [11:0]      addr_p0;
  logic [2:0]       cmd_p0;
  logic [63:0]      wdata_p0;
  logic [63:0]      rdata_p1;
  logic             xcpt_p1;
  logic             replay_p1;

  assign expire = WD_ON && (cnt_q == CNT_LAST);

  // Control state: FSM, drain flag, watchdog counter and sticky timeout.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      drain_q   <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic: handshake, response capture, watchdog and flush handling.
  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    cnt_d        = cnt_q;
    timeout_d    = timeout_q;
    capture      = 1'b0;
    take_resp    = 1'b0;
    take_timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (drain_q) begin
          // An orphaned response is still in flight; block new captures until it lands.
          if (resp_valid_i || expire) drain_d = 1'b0;
          else                        cnt_d   = cnt_q + 1'b1;
        end else if (csr_ena_i && !flush_i) begin
          capture = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (flush_i) begin
          state_d = S_IDLE;
          // The CSR unit took the request in this very cycle, so a response will follow.
          if (req_ready_i) begin
            drain_d = 1'b1;
            cnt_d   = '0;
          end
        end else if (req_ready_i) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (flush_i) begin
          state_d = S_IDLE;
          drain_d = !resp_valid_i && !expire;
          cnt_d   = cnt_q + 1'b1;
        end else if (resp_valid_i) begin
          take_resp = 1'b1;
          state_d   = S_DONE;
        end else if (expire) begin
          take_timeout = 1'b1;
          timeout_d    = 1'b1;
          state_d      = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Stage p0: request fields captured from WB, held stable until the handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_p0  <= '0;
      cmd_p0   <= '0;
      wdata_p0 <= '0;
    end else if (capture) begin
      addr_p0  <= csr_addr_i;
      cmd_p0   <= csr_cmd_i;
      wdata_p0 <= csr_wdata_i;
    end
  end

  // Stage p1: result latched from the CSR unit, or forced to an exception on timeout.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_p1  <= '0;
      xcpt_p1   <= 1'b0;
      replay_p1 <= 1'b0;
    end else if (take_resp) begin
      rdata_p1  <= resp_rdata_i;
      xcpt_p1   <= resp_xcpt_i;
      replay_p1 <= resp_replay_i;
    end else if (take_timeout) begin
      rdata_p1  <= '0;
      xcpt_p1   <= 1'b1;
      replay_p1 <= 1'b0;
    end
  end

  assign req_valid_o = (state_q == S_REQ);
  assign req_addr_o  = addr_p0;
  assign req_cmd_o   = cmd_p0;
  assign req_wdata_o = wdata_p0;
  assign done_o      = (state_q == S_DONE) && !flush_i;
  assign rdata_o     = rdata_p1;
  assign xcpt_o      = xcpt_p1;
  assign replay_o    = replay_p1;
  assign timeout_o   = timeout_q;
  assign stall_o     = (state_q == S_REQ) || (state_q == S_WAIT) ||
                       ((state_q == S_IDLE) && (csr_ena_i || drain_q));

endmodule
